// File: rtl/rd_req_engine_pkg.sv
// Shared types and helpers for the host-memory read request engine.
package rd_req_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rd_req_engine_if.sv
// Control, host request/response and output-stream signals of rd_req_engine.
interface rd_req_engine_if #(
    parameter int CL_ADDR_WIDTH = 64,
    parameter int DATA_WIDTH    = 512
);
    logic                     start;
    logic [CL_ADDR_WIDTH-1:0] base_addr;
    logic [CL_ADDR_WIDTH-1:0] size;
    logic                     rd_req_valid;
    logic [CL_ADDR_WIDTH-1:0] rd_req_addr;
    logic                     rd_req_almfull;
    logic                     rd_rsp_valid;
    logic [DATA_WIDTH-1:0]    rd_rsp_data;
    logic                     out_valid;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_ready;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        input  start, base_addr, size, rd_req_almfull, rd_rsp_valid, rd_rsp_data, out_ready,
        output rd_req_valid, rd_req_addr, out_valid, out_data, busy, done, err
    );

    modport slave (
        output start, base_addr, size, rd_req_almfull, rd_rsp_valid, rd_rsp_data, out_ready,
        input  rd_req_valid, rd_req_addr, out_valid, out_data, busy, done, err
    );
endinterface

// File: rtl/rd_req_engine_fifo.sv
// Line buffer with a registered head: a push into an empty FIFO is visible next cycle.
module rd_line_fifo
    import rd_req_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [cnt_bits(DEPTH)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_bits(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_rem;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q, head_d;
    logic                  do_pop, do_push;

    always_comb begin
        do_pop   = pop_i && valid_q;
        // a full FIFO still accepts a push when the head leaves in the same cycle
        do_push  = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
        cnt_rem  = cnt_q - CW'(do_pop);
        cnt_d    = cnt_rem + CW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        head_d   = (cnt_rem == '0) ? data_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(do_push);
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= (cnt_d != '0);
            if (cnt_d != '0) data_q <= head_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
endmodule

// File: rtl/rd_req_engine.sv
// Issues sequential cache-line reads under a credit limit and streams the returned lines out.
module rd_req_engine
    import rd_req_pkg::*;
#(
    parameter int CL_ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 16
) (
    input logic             clk,
    input logic             rst_n,
    rd_req_engine_if.master bus
);
    localparam int AW = CL_ADDR_WIDTH;
    localparam int CW = cnt_bits(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CRED_MAX = CW'(MAX_OUTSTANDING);

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q, base_d, size_q, size_d;
    logic [AW-1:0]   issued_q, issued_d, delivered_q, delivered_d;
    logic [AW-1:0]   rd_req_addr_q;
    logic [CW-1:0]   credits_q, credits_d, inflight_q, inflight_d;
    logic            rd_req_valid_q, busy_q, done_q, err_q, err_d;

    logic                  fifo_valid, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [CW-1:0]         fifo_cnt;
    logic                  issue, pop, rsp_ok, stray, ovf;

    rd_line_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_OUTSTANDING)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rsp_ok),
        .data_i  (bus.rd_rsp_data),
        .pop_i   (bus.out_ready),
        .valid_o (fifo_valid),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        issue  = (state_q == ISSUE) && (credits_q != '0) && !bus.rd_req_almfull && (issued_q < size_q);
        pop    = bus.out_ready && !fifo_empty;
        rsp_ok = bus.rd_rsp_valid && (inflight_q != '0);
        stray  = bus.rd_rsp_valid && (inflight_q == '0);
        ovf    = rsp_ok && fifo_full && !pop;

        credits_d   = credits_q - CW'(issue) + CW'(pop);
        inflight_d  = inflight_q + CW'(issue) - CW'(rsp_ok);
        err_d       = err_q | stray | ovf;
        state_d     = state_q;
        base_d      = base_q;
        size_d      = size_q;
        issued_d    = issued_q + AW'(issue);
        delivered_d = delivered_q + AW'(pop);

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    base_d      = bus.base_addr;
                    size_d      = bus.size;
                    issued_d    = '0;
                    delivered_d = '0;
                    state_d     = (bus.size == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: if (issue && (issued_q + AW'(1) == size_q)) state_d = DRAIN;
            // every line delivered and nothing left behind in the buffer
            DRAIN: if ((delivered_d == size_q) && (fifo_cnt == CW'(pop))) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            base_q         <= '0;
            size_q         <= '0;
            issued_q       <= '0;
            delivered_q    <= '0;
            credits_q      <= CRED_MAX;
            inflight_q     <= '0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            size_q         <= size_d;
            issued_q       <= issued_d;
            delivered_q    <= delivered_d;
            credits_q      <= credits_d;
            inflight_q     <= inflight_d;
            rd_req_valid_q <= issue;
            if (issue) rd_req_addr_q <= base_q + issued_q;
            busy_q         <= (state_d == ISSUE) || (state_d == DRAIN);
            done_q         <= (state_d == DONE);
            err_q          <= err_d;
        end
    end

    assign bus.rd_req_valid = rd_req_valid_q;
    assign bus.rd_req_addr  = rd_req_addr_q;
    assign bus.out_valid    = fifo_valid;
    assign bus.out_data     = fifo_data;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_rd_req_engine.sv
// Self-checking bench: in-order host responder plus address/data queue reference model.
module tb_rd_req_engine;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int MO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rd_req_engine_if #(.CL_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    rd_req_engine #(
        .CL_ADDR_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] size;
        int            mode;
        logic [AW-1:0] last_addr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;
    int nreq, npop, first_req, last_req, first_pop, last_pop;
    bit stray_go = 1'b0;
    bit early_done;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    pend_t pend[$];

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
        return {8{a ^ 64'hC3C3_5A5A_0F0F_9669}};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        case (mode)
            0: begin bus.out_ready = 1'b1; bus.rd_req_almfull = 1'b0; end
            1: begin bus.out_ready = 1'b1; bus.rd_req_almfull = (cyc % 2) == 1; end
            2: begin
                bus.out_ready      = $urandom_range(0, 3) != 0;
                bus.rd_req_almfull = $urandom_range(0, 3) == 0;
            end
            default: begin bus.out_ready = 1'b0; bus.rd_req_almfull = 1'b0; end
        endcase
    endtask

    // One clock: snapshot what the DUT sees, advance, score, then act as the host.
    task automatic tick();
        logic pv, pr, pal;
        logic [DW-1:0] pd;
        pend_t p;
        pv = bus.out_valid; pr = bus.out_ready; pal = bus.rd_req_almfull; pd = bus.out_data;
        @(posedge clk);
        #1;
        cyc++;
        if (pv && pr) begin
            npop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if (exp_data.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("out_data", pd, exp_data.pop_front());
        end
        if (bus.rd_req_valid) begin
            nreq++;
            if (first_req < 0) first_req = cyc;
            last_req  = cyc;
            last_addr = bus.rd_req_addr;
            chk("req_while_almfull", {511'b0, pal}, 0);
            if (exp_addr.size() == 0) chk("req_unexpected", 1, 0);
            else chk("req_addr", bus.rd_req_addr, exp_addr.pop_front());
            p.addr = bus.rd_req_addr;
            p.due  = cyc + 2;
            pend.push_back(p);
        end
        bus.rd_rsp_valid = 1'b0;
        if (stray_go) begin
            bus.rd_rsp_valid = 1'b1;
            bus.rd_rsp_data  = '1;
            stray_go = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.rd_rsp_valid = 1'b1;
            bus.rd_rsp_data  = mkdata(pend[0].addr);
            void'(pend.pop_front());
        end
    endtask

    task automatic clear_model();
        exp_addr.delete();
        exp_data.delete();
        nreq = 0; npop = 0; first_req = -1; first_pop = -1; last_req = 0; last_pop = 0;
        early_done = 1'b0;
    endtask

    task automatic do_reset(input bit clear_host);
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("rst_rd_req_valid", bus.rd_req_valid, 0);
        chk("rst_rd_req_addr", bus.rd_req_addr, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        if (clear_host) pend.delete();
        clear_model();
        mode = 0;
        drive();
        tick();
        tick();
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] sz);
        logic [AW-1:0] a;
        clear_model();
        for (int i = 0; i < int'(sz); i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mkdata(a));
        end
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.size = sz;
        drive();
        tick();
        bus.start = 1'b0;
        chk("req_same_cycle_as_start", bus.rd_req_valid, 0);
        chk("busy_after_start", bus.busy, sz != 0);
        chk("done_after_start", bus.done, sz == 0);
    endtask

    task automatic finish_job(input int sz, input int exp_err);
        int budget = 0;
        while (npop < sz && budget < 3000) begin
            drive();
            tick();
            budget++;
            if (npop < sz && bus.done) early_done = 1'b1;
        end
        chk("lines_delivered", npop, sz);
        chk("done_after_last_pop", bus.done, 1);
        chk("busy_after_last_pop", bus.busy, 0);
        chk("done_early", early_done, 0);
        chk("requests_issued", nreq, sz);
        chk("addr_left", exp_addr.size(), 0);
        if (exp_err >= 0) chk("err", bus.err, exp_err[0]);
        drive();
        tick();
        chk("no_req_after_done", nreq, sz);
        chk("done_held", bus.done, 1);
    endtask

    vec_t vecs[5];

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.size = '0;
        bus.rd_req_almfull = 1'b0; bus.rd_rsp_valid = 1'b0; bus.rd_rsp_data = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{64'h100, 64'd4, 0, 64'h103};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd4, 0, 64'h1};
        vecs[2] = '{64'h40, 64'd8, 1, 64'h47};
        vecs[3] = '{64'h1000, 64'd20, 0, 64'h1013};
        vecs[4] = '{64'h7, 64'd5, 2, 64'hB};

        do_reset(1'b1);

        for (int v = 0; v < 5; v++) begin
            mode = vecs[v].mode;
            start_job(vecs[v].base, vecs[v].size);
            finish_job(int'(vecs[v].size), 0);
            chk("last_addr", last_addr, vecs[v].last_addr);
            if (vecs[v].mode == 0) begin
                chk("req_back_to_back", last_req - first_req, int'(vecs[v].size) - 1);
                chk("pop_back_to_back", last_pop - first_pop, int'(vecs[v].size) - 1);
            end
        end

        // credit stall: consumer blocked, only MO requests may go out
        mode = 3;
        start_job(64'h3000, 64'd40);
        for (int i = 0; i < 40; i++) begin drive(); tick(); end
        chk("stall_reqs", nreq, MO);
        chk("stall_out_valid", bus.out_valid, 1);
        mode = 0;
        finish_job(40, 0);

        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0] b;
            int sz;
            b  = {$urandom, $urandom};
            sz = $urandom_range(1, 30);
            mode = 2;
            start_job(b, AW'(sz));
            finish_job(sz, 0);
        end

        mode = 0;
        start_job(64'h55, 64'd0);
        for (int i = 0; i < 3; i++) begin drive(); tick(); end
        chk("size0_no_req", nreq, 0);
        chk("size0_done", bus.done, 1);

        do_reset(1'b1);
        stray_go = 1'b1;
        tick();
        tick();
        chk("stray_err", bus.err, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("stray_err_sticky", bus.err, 1);

        // reset with requests still outstanding at the host
        do_reset(1'b1);
        mode = 0;
        start_job(64'h2000, 64'd8);
        for (int i = 0; i < 50 && nreq < 3; i++) begin drive(); tick(); end
        chk("midop_reqs_before_reset", nreq, 3);
        do_reset(1'b0);
        for (int i = 0; i < 20 && pend.size() > 0; i++) tick();
        chk("host_drained", pend.size(), 0);
        start_job(64'h500, 64'd2);
        finish_job(2, -1);

        do_reset(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
